// File: rtl/red_k_arbiter.sv
// Round-robin arbiter sharing one (a*b) mod 3329 multiply/Barrett-reduce pipeline among N_REQ clients.
// Optional stall counter on perf_stall_o is built when RED_K_ARB_PERF_EN is defined.
module red_k_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*12-1:0] req_a_i,
    input  logic [N_REQ*12-1:0] req_b_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [11:0]         res_data_o,
    output logic [ID_W-1:0]     res_id_o,
    output logic [15:0]         perf_stall_o
);

    // Barrett reduction by 3329 with m = floor(2^24/3329); the quotient estimate is short by at most one.
    function automatic logic [11:0] red_k(input logic [23:0] x);
        logic [36:0] t;
        logic [12:0] q;
        logic [24:0] qm;
        logic [13:0] r;
        t  = {13'd0, x} * 37'd5039;
        q  = 13'(t >> 24);
        qm = 25'(q) * 25'd3329;
        r  = 14'({1'b0, x} - qm);
        if (r >= 14'd3329) begin
            r = r - 14'd3329;
        end
        return 12'(r);
    endfunction

    logic                r_vld_p1;
    logic [23:0]         r_prod_p1;
    logic [ID_W-1:0]     r_id_p1;
    logic                r_vld_p2;
    logic [11:0]         r_res_p2;
    logic [ID_W-1:0]     r_id_p2;
    logic [ID_W-1:0]     r_rr_ptr;

    logic                w_adv1;
    logic                w_adv2;
    logic                w_accept;
    logic                w_found;
    logic [ID_W-1:0]     w_gnt_id;
    logic [N_REQ-1:0]    w_gnt_oh;
    logic [11:0]         w_a;
    logic [11:0]         w_b;

    assign w_adv2   = !r_vld_p2 | res_ready_i;
    assign w_adv1   = !r_vld_p1 | w_adv2;
    assign w_accept = w_adv1 & w_found;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        logic [ID_W-1:0] idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        idx      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
            if (!w_found && req_valid_i[idx]) begin
                w_found  = 1'b1;
                w_gnt_id = idx;
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        w_a      = '0;
        w_b      = '0;
        if (w_accept) begin
            w_gnt_oh[w_gnt_id] = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_a = req_a_i[12*i +: 12];
                w_b = req_b_i[12*i +: 12];
            end
        end
    end

    assign req_ready_o = w_gnt_oh;

    // Stage 1: multiply the granted operands
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1  <= 1'b0;
            r_prod_p1 <= '0;
            r_id_p1   <= '0;
            r_rr_ptr  <= ID_W'(N_REQ - 1);
        end else if (w_adv1) begin
            r_vld_p1  <= w_accept;
            r_prod_p1 <= {12'd0, w_a} * {12'd0, w_b};
            r_id_p1   <= w_gnt_id;
            if (w_accept) begin
                r_rr_ptr <= w_gnt_id;
            end
        end
    end

    // Stage 2: reduce and hold the result for the consumer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p2 <= 1'b0;
            r_res_p2 <= '0;
            r_id_p2  <= '0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            r_res_p2 <= red_k(r_prod_p1);
            r_id_p2  <= r_id_p1;
        end
    end

    assign res_valid_o = r_vld_p2;
    assign res_data_o  = r_res_p2;
    assign res_id_o    = r_id_p2;

`ifdef RED_K_ARB_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (r_vld_p2 && !res_ready_i) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign perf_stall_o = r_stall_cnt;
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_red_k_arbiter.sv
// Bench for red_k_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_red_k_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
`ifdef RED_K_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                clk_i;
    logic                rst_ni;
    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ*12-1:0] req_a_i;
    logic [N_REQ*12-1:0] req_b_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic                res_valid_o;
    logic                res_ready_i;
    logic [11:0]         res_data_o;
    logic [ID_W-1:0]     res_id_o;
    logic [15:0]         perf_stall_o;

    red_k_arbiter #(.N_REQ(N_REQ)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_ready_o  (req_ready_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_id_o     (res_id_o),
        .perf_stall_o (perf_stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int get_op(input logic [N_REQ*12-1:0] v, input int i);
        return int'(12'(v >> (12 * i)));
    endfunction

    // Reference model: in-order queue of accepted operations, capacity two, fixed two-cycle latency.
    typedef struct {
        int id;
        int data;
        int t;
    } ent_t;

    ent_t             q[$];
    int               m_ptr;
    int               m_stall;
    int               now;
    logic [N_REQ-1:0] acc_last;

    always @(negedge clk_i) begin
        logic [N_REQ-1:0] eg;
        int               gid;
        bit               blocked;
        bit               ev;
        ent_t             e;
        if (!rst_ni) begin
            q.delete();
            m_ptr    = N_REQ - 1;
            m_stall  = 0;
            now      = 0;
            acc_last = '0;
        end else begin
            now++;
            blocked = (q.size() == 2) && !res_ready_i;
            eg  = '0;
            gid = -1;
            if (!blocked) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    if (gid < 0 && req_valid_i[(m_ptr + k) % N_REQ]) gid = (m_ptr + k) % N_REQ;
                end
            end
            if (gid >= 0) eg[gid] = 1'b1;
            chk("ready", 32'(req_ready_o), 32'(eg));
            ev = (q.size() > 0) && (q[0].t + 2 <= now);
            chk("res_valid", 32'(res_valid_o), 32'(ev));
            if (ev) begin
                chk("res_data", 32'(res_data_o), q[0].data);
                chk("res_id", 32'(res_id_o), q[0].id);
            end
            chk("perf", 32'(perf_stall_o), PERF ? m_stall : 0);
            if (ev && !res_ready_i && m_stall < 65535) m_stall++;
            if (ev && res_ready_i) void'(q.pop_front());
            if (gid >= 0) begin
                e.id   = gid;
                e.data = (get_op(req_a_i, gid) * get_op(req_b_i, gid)) % 3329;
                e.t    = now;
                q.push_back(e);
                m_ptr = gid;
            end
            acc_last = req_valid_i & req_ready_o;
        end
    end

    task automatic set_req(input int i, input bit v, input int a, input int b);
        req_valid_i[i]      = v;
        req_a_i[12*i +: 12] = 12'(a);
        req_b_i[12*i +: 12] = 12'(b);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        res_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 32'(res_valid_o), 0);
        chk("rst_data", 32'(res_data_o), 0);
        chk("rst_id", 32'(res_id_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_perf", 32'(perf_stall_o), 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic single(input string tag, input int id, input int a, input int b, input int exp);
        set_req(id, 1'b1, a, b);
        @(negedge clk_i);
        chk({tag, "_gnt"}, 32'(req_ready_o), 32'(1) << id);
        @(posedge clk_i);
        #1 req_valid_i[id] = 1'b0;
        @(negedge clk_i);
        chk({tag, "_lat1"}, 32'(res_valid_o), 0);
        @(negedge clk_i);
        chk({tag, "_valid"}, 32'(res_valid_o), 1);
        chk({tag, "_data"}, 32'(res_data_o), exp);
        chk({tag, "_id"}, 32'(res_id_o), id);
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid_i[i] || acc_last[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3328)), int'($urandom_range(0, 3328)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid_i[i] = 1'b0;
                end
            end
            res_ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    logic [11:0]     frz_data;
    logic [ID_W-1:0] frz_id;

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        res_ready_i = 1'b1;

        do_reset();
        single("t1", 0, 3328, 3328, 1);
        single("t2a", 2, 1234, 2000, 1211);
        single("t2b", 2, 0, 3000, 0);

        // All four requesters held valid: strict rotation starting at req0.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 100 + 7 * i, 3000 - 11 * i);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk("t3_gnt", 32'(req_ready_o), 32'(1) << (k % N_REQ));
            if (k >= 2) begin
                chk("t3_valid", 32'(res_valid_o), 1);
                chk("t3_id", 32'(res_id_o), (k - 2) % N_REQ);
            end
        end
        @(posedge clk_i);
        #1 req_valid_i = '0;
        repeat (3) @(negedge clk_i);

        // Backpressure with req1 and req3 competing.
        @(posedge clk_i);
        #1;
        set_req(1, 1'b1, 100, 200);
        set_req(3, 1'b1, 3000, 3000);
        res_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (k == 0) begin
                frz_data = res_data_o;
                frz_id   = res_id_o;
                chk("t4_first_data", 32'(res_data_o), 26);
                chk("t4_first_id", 32'(res_id_o), 1);
            end
            chk("t4_hold_valid", 32'(res_valid_o), 1);
            chk("t4_hold_data", 32'(res_data_o), 32'(frz_data));
            chk("t4_hold_id", 32'(res_id_o), 32'(frz_id));
            chk("t4_ready_zero", 32'(req_ready_o), 0);
        end
        @(posedge clk_i);
        #1 res_ready_i = 1'b1;
        repeat (6) @(negedge clk_i);
        @(posedge clk_i);
        #1 req_valid_i = '0;
        repeat (4) @(negedge clk_i);
        chk("t4_drain", q.size(), 0);

        // Stall counter over seven stalled cycles.
        do_reset();
        set_req(0, 1'b1, 5, 7);
        res_ready_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        #1 req_valid_i[0] = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t6_valid", 32'(res_valid_o), 1);
        repeat (7) @(negedge clk_i);
        chk("t6_perf", 32'(perf_stall_o), PERF ? 7 : 0);
        @(posedge clk_i);
        #1 res_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Asynchronous reset with both stages occupied.
        @(posedge clk_i);
        #1;
        set_req(0, 1'b1, 11, 13);
        set_req(1, 1'b1, 17, 19);
        res_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1 req_valid_i = '0;
        @(negedge clk_i);
        chk("t5_full", 32'(res_valid_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t5_async_valid", 32'(res_valid_o), 0);
        chk("t5_async_data", 32'(res_data_o), 0);
        chk("t5_async_id", 32'(res_id_o), 0);
        chk("t5_async_perf", 32'(perf_stall_o), 0);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        res_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t5_no_stale", 32'(res_valid_o), 0);
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 3328 - i, 2 + i);
        @(negedge clk_i);
        chk("t5_restart_gnt", 32'(req_ready_o), 32'(1));
        @(posedge clk_i);
        #1 req_valid_i = '0;
        repeat (3) @(negedge clk_i);

        rand_phase(500);
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        res_ready_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
